test_018: RTL and testbench

- Self-checking hardware test block: one request/busy method `test(idx)` returning a 1-bit pass flag.
- On request it:
  - fills an internal RAM with an idx-dependent pattern;
  - reads the RAM back and accumulates a sum;
  - compares the sum against the closed-form expected value.
- Top-level leaf driven by a simulation harness or a system-level test sequencer.

---
 rtl/test_018_if.sv | 21 ++
 rtl/test_018.sv | 100 ++++++++++
 tb/tb_test_018.sv | 133 +++++++++++++
 3 files changed

// File: rtl/test_018_if.sv
// Method-call port bundle for test_018: request/argument from the caller, busy/result back.
interface test_018_if;
    logic [31:0] test_idx;
    logic        test_req;
    logic        test_busy;
    logic        test_return;

    modport master (
        output test_idx,
        output test_req,
        input  test_busy,
        input  test_return
    );

    modport slave (
        input  test_idx,
        input  test_req,
        output test_busy,
        output test_return
    );
endinterface

// File: rtl/test_018.sv
// RAM self-test: writes STEP*i+idx to every word, sums the read-back and compares
// against the closed-form total; test_return reports the outcome of the last run.
module test_018 #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned STEP  = 3
) (
    input  logic       clk,
    input  logic       reset,
    test_018_if.slave  bus
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] LAST_WR = CW'(DEPTH - 1);
    localparam logic [CW-1:0] LAST_RD = CW'(DEPTH);
    localparam logic [63:0] BASE64 = 64'(STEP) * 64'(DEPTH) * 64'(DEPTH - 1) / 64'd2;
    localparam logic [31:0] BASE   = BASE64[31:0];

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        CHECK = 2'd3
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [31:0]     idx_r;
    logic [CW-1:0]   cnt;
    logic [31:0]     sum;
    logic [31:0]     rd_data;
    logic [31:0]     wr_data;
    logic [31:0]     expected;
    logic [AW-1:0]   addr;
    logic            ret_r;
    logic [31:0]     mem [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (bus.test_req) state_next = WRITE;
            WRITE:   if (cnt == LAST_WR) state_next = READ;
            READ:    if (cnt == LAST_RD) state_next = CHECK;
            CHECK:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign addr     = cnt[AW-1:0];
    assign wr_data  = 32'(STEP) * 32'(cnt) + idx_r;
    // DEPTH is a power of two, so DEPTH*idx reduces to a shift.
    assign expected = BASE + (idx_r << AW);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_r <= '0;
            cnt   <= '0;
            sum   <= '0;
            ret_r <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.test_req) begin
                        idx_r <= bus.test_idx;
                        cnt   <= '0;
                        sum   <= '0;
                    end
                end
                WRITE: begin
                    cnt <= (cnt == LAST_WR) ? '0 : cnt + 1'b1;
                end
                READ: begin
                    cnt <= cnt + 1'b1;
                    // Read data lags the address by one cycle, so cycle 0 has nothing to add.
                    if (cnt != '0) sum <= sum + rd_data;
                end
                CHECK: begin
                    ret_r <= (sum == expected);
                end
                default: ;
            endcase
        end
    end

    // RAM contents survive reset; only the control path is cleared.
    always_ff @(posedge clk) begin
        if (state == WRITE) mem[addr] <= wr_data;
        if (state == READ) rd_data <= mem[addr];
    end

    assign bus.test_busy   = (state != IDLE);
    assign bus.test_return = ret_r;
endmodule

// File: tb/tb_test_018.sv
// Randomized self-checking bench for test_018 against a summation reference model.
module tb_test_018;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned STEP  = 3;
    localparam int unsigned BUSY_CYCLES = 2 * DEPTH + 2;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;

    test_018_if bus ();

    test_018 #(.DEPTH(DEPTH), .STEP(STEP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Reference: literally add every written word, then judge against the closed form.
    function automatic logic model_return(input logic [31:0] idx);
        logic [31:0] total;
        logic [31:0] closed;
        total = '0;
        for (int unsigned k = 0; k < DEPTH; k++) total += 32'(STEP * k) + idx;
        closed = 32'(STEP * DEPTH * (DEPTH - 1) / 2) + 32'(DEPTH) * idx;
        return total == closed;
    endfunction

    // Issue one request at a negedge and follow the run to completion.
    task automatic run_one(input logic [31:0] idx, input bit disturb, input string tag);
        int unsigned cnt;
        logic prev_ret;
        prev_ret = bus.test_return;
        bus.test_idx = idx;
        bus.test_req = 1'b1;
        @(negedge clk);
        bus.test_req = 1'b0;
        check({tag, "_busy_rise"}, 32'(bus.test_busy), 32'd1);
        cnt = 0;
        while (bus.test_busy && cnt < 200) begin
            cnt++;
            if (disturb && cnt == 5) begin
                bus.test_idx = ~idx;
                bus.test_req = 1'b1;
            end
            if (disturb && cnt == 8) bus.test_req = 1'b0;
            if (cnt == 20) check({tag, "_ret_hold"}, 32'(bus.test_return), 32'(prev_ret));
            @(negedge clk);
        end
        check({tag, "_busy_len"}, cnt, BUSY_CYCLES);
        check({tag, "_return"}, 32'(bus.test_return), 32'(model_return(idx)));
        @(negedge clk);
        check({tag, "_idle"}, 32'(bus.test_busy), 32'd0);
    endtask

    initial begin
        int unsigned cnt;
        n_checks = 0;
        n_pass   = 0;
        reset = 1'b0;
        bus.test_req = 1'b0;
        bus.test_idx = '0;
        repeat (6) @(negedge clk);
        check("reset_busy", 32'(bus.test_busy), 32'd0);
        check("reset_return", 32'(bus.test_return), 32'd0);
        reset = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.test_busy !== 1'b0 || bus.test_return !== 1'b0 || i == 99) begin
                check("idle_busy", 32'(bus.test_busy), 32'd0);
                check("idle_return", 32'(bus.test_return), 32'd0);
            end
        end

        run_one(32'h0000_0000, 1'b0, "basic");

        // Held request: exactly one idle cycle between back-to-back runs.
        bus.test_idx = '0;
        bus.test_req = 1'b1;
        for (int r = 0; r < 3; r++) begin
            cnt = 0;
            while (!bus.test_busy && cnt < 10) begin
                cnt++;
                @(negedge clk);
            end
            check("held_start", 32'(bus.test_busy), 32'd1);
            cnt = 0;
            while (bus.test_busy && cnt < 200) begin
                cnt++;
                @(negedge clk);
            end
            check("held_len", cnt, BUSY_CYCLES);
            check("held_return", 32'(bus.test_return), 32'(model_return(32'h0)));
            if (r == 2) bus.test_req = 1'b0;
            @(negedge clk);
            check("held_regap", 32'(bus.test_busy), (r == 2) ? 32'd0 : 32'd1);
        end

        run_one(32'hFFFF_FFFF, 1'b0, "wrap_ff");
        run_one(32'h1234_5678, 1'b0, "wrap_mix");
        run_one(32'h0000_0007, 1'b1, "disturb");

        // Abort a run at busy cycle 10, then verify a clean restart.
        bus.test_idx = 32'h0000_0009;
        bus.test_req = 1'b1;
        @(negedge clk);
        bus.test_req = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_busy", 32'(bus.test_busy), 32'd0);
        check("abort_return", 32'(bus.test_return), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        run_one(32'h0000_0005, 1'b0, "after_abort");

        for (int r = 0; r < 12; r++) run_one($urandom, r[0], "rand");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
